regfile_access_controller: RTL and testbench
============================================

# regfile_access_controller

Initiator-side controller that drives the 16×16 register file's write and read ports (WR, DA, D, AA, BA) and collects its A/B read data. It accepts WRITE, READ-pair, CLEAR-all and NOP commands over a valid/ready interface. It returns read results over a valid/ready response interface. It sits between the datapath control logic and the register file, replacing direct pin-wiggling of the register file.

## Interface
- DATA_WIDTH, 16, register width
- ADDR_WIDTH, 4, register address width
- NUM_REGS, 16, registers swept by CLEAR (2**ADDR_WIDTH)

- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  2  00 NOP, 01 WRITE, 10 READ, 11 CLEAR
- cmd_dst  in  ADDR_WIDTH  write destination address
- cmd_src_a  in  ADDR_WIDTH  read address for port A
- cmd_src_b  in  ADDR_WIDTH  read address for port B
- cmd_data  in  DATA_WIDTH  write data
- rsp_valid  out  1  read result available
- rsp_ready  in  1  consumer takes result
- rsp_a  out  DATA_WIDTH  captured R[src_a]
- rsp_b  out  DATA_WIDTH  captured R[src_b]
- busy  out  1  state is not IDLE
- WR  out  1  register file write enable
- DA  out  ADDR_WIDTH  register file write address
- D  out  DATA_WIDTH  register file write data
- AA  out  ADDR_WIDTH  register file read address A
- BA  out  ADDR_WIDTH  register file read address B
- A  in  DATA_WIDTH  register file read data A (combinational from AA)
- B  in  DATA_WIDTH  register file read data B (combinational from BA)

## Operation
- Register file contract: writes commit on rising Clock when WR=1; A/B are combinational from AA/BA.
- FSM states: IDLE, WRITE, READ, RESP, CLEAR.
- IDLE: cmd_ready=1; handshake = cmd_valid & cmd_ready.
  - NOP: accepted; no state change.
  - WRITE: register DA←cmd_dst, D←cmd_data, WR←1; go to WRITE.
  - READ: register AA←cmd_src_a, BA←cmd_src_b; go to READ.
  - CLEAR: DA←0, D←0, WR←1; go to CLEAR.
- WRITE: one cycle. Then WR←0 and the FSM returns to IDLE.
- READ: one cycle. rsp_a←A, rsp_b←B, rsp_valid←1; go to RESP.
- RESP: hold rsp_valid/rsp_a/rsp_b stable until rsp_ready=1. On that cycle, rsp_valid←0 and the FSM goes to IDLE.
- CLEAR: WR=1 with D=0 while DA steps 0..NUM_REGS-1, one address per cycle. When DA=NUM_REGS-1, WR←0, DA←0 and the FSM goes to IDLE. DA never wraps past NUM_REGS-1.
- cmd_ready=0 in every state except IDLE; cmd_* is ignored there.
- AA/BA hold their last values outside READ. DA/D hold their last values when WR=0, except DA←0 at the end of CLEAR.
- Reset (asynchronous, mid-operation included): state←IDLE and WR←0 immediately. Any sweep or pending response is abandoned with no partial rsp_valid.

## Timing
- Reset values: WR=0, DA=0, D=0, AA=0, BA=0, rsp_valid=0, rsp_a=0, rsp_b=0, busy=0. cmd_ready=1 as soon as Reset is high (IDLE).
- WRITE accepted at cycle N: WR=1 during N+1; register updated at the N+1 edge. cmd_ready returns at N+2. A READ accepted at N+2 returns the new value.
- READ accepted at N: AA/BA valid during N+1. rsp_valid=1 from N+2. rsp_ready=1 during N+2 gives cmd_ready=1 at N+3.
- CLEAR accepted at N: WR=1 during N+1..N+NUM_REGS. cmd_ready=1 at N+NUM_REGS+1.
- Peak throughput: one WRITE per 2 cycles; one READ per 3 cycles with an always-ready consumer.

## Structure
- Shared package regfile_pkg holds:
  - op-code constants OP_NOP/OP_WRITE/OP_READ/OP_CLEAR;
  - the FSM state typedef;
  - DATA_WIDTH/ADDR_WIDTH defaults, which the register file also uses.
- No sub-module is natural. The FSM, the CLEAR address counter (the DA register itself) and the response registers sit in one module.

## Test plan
- WRITE dst=3 data=16'hBEEF, then READ a=3 b=0 after reset -> WR high exactly one cycle with DA=3; rsp_a=16'hBEEF, rsp_b=16'h0000.
- WRITE all 16 registers with 16'h1000+i, then CLEAR, then READ a=15 b=7 -> WR high 16 consecutive cycles with DA 0..15 and D=0; rsp_a=rsp_b=0; busy low at cycle N+17.
- READ a=5 b=5 after WRITE 5←16'h00A5, with rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_a=rsp_b=16'h00A5 stable; cmd_ready=0 throughout; release -> IDLE next cycle.
- cmd_valid held high with WRITE during RESP and CLEAR -> no extra WR pulses; the command is accepted only once cmd_ready=1.
- Reset driven low mid-CLEAR, with DA=6 -> WR, busy and rsp_valid drop immediately; registers 0..5 cleared and 6..15 unchanged on later reads.
- NOP stream of 5 commands -> cmd_ready stays 1, WR never asserted, no response.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the 16x16 register file and its access controller:
// opcodes, FSM state encoding and default geometry.
package regfile_pkg;

  localparam int unsigned RF_DATA_WIDTH = 16;
  localparam int unsigned RF_ADDR_WIDTH = 4;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_WRITE = 3'd1;
  localparam state_t ST_READ  = 3'd2;
  localparam state_t ST_RESP  = 3'd3;
  localparam state_t ST_CLEAR = 3'd4;

endpackage

// File: rtl/regfile_access_controller.sv
// Command-driven front end for the register file: single writes, paired reads
// with a held response, and a full-array clear sweep.
module regfile_access_controller
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH-1:0] cmd_src_a,
  input  logic [ADDR_WIDTH-1:0] cmd_src_b,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_a,
  output logic [DATA_WIDTH-1:0] rsp_b,
  output logic                  busy,
  output logic                  WR,
  output logic [ADDR_WIDTH-1:0] DA,
  output logic [DATA_WIDTH-1:0] D,
  output logic [ADDR_WIDTH-1:0] AA,
  output logic [ADDR_WIDTH-1:0] BA,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  state_t state;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      WR        <= 1'b0;
      DA        <= '0;
      D         <= '0;
      AA        <= '0;
      BA        <= '0;
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WRITE: begin
                DA    <= cmd_dst;
                D     <= cmd_data;
                WR    <= 1'b1;
                state <= ST_WRITE;
              end
              OP_READ: begin
                AA    <= cmd_src_a;
                BA    <= cmd_src_b;
                state <= ST_READ;
              end
              OP_CLEAR: begin
                DA    <= '0;
                D     <= '0;
                WR    <= 1'b1;
                state <= ST_CLEAR;
              end
              default: ;
            endcase
          end
        end
        ST_WRITE: begin
          WR    <= 1'b0;
          state <= ST_IDLE;
        end
        ST_READ: begin
          rsp_a     <= A;
          rsp_b     <= B;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          // DA doubles as the sweep counter; it parks at 0 when the sweep ends.
          if (DA == LAST_ADDR) begin
            WR    <= 1'b0;
            DA    <= '0;
            state <= ST_IDLE;
          end else begin
            DA <= DA + ADDR_WIDTH'(1);
          end
        end
        default: begin
          WR    <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_controller.sv
// Self-checking bench: behavioural register file plus a command-level model of
// the expected register contents, driven by directed and random commands.
module tb_regfile_access_controller;
  import regfile_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  logic          Clock, Reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_dst, cmd_src_a, cmd_src_b;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_a, rsp_b;
  logic          busy, WR;
  logic [AW-1:0] DA, AA, BA;
  logic [DW-1:0] D, A, B;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf  [NR] = '{default: '0};
  logic [DW-1:0] mdl [NR] = '{default: '0};

  regfile_access_controller #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_REGS  (NR)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_dst  (cmd_dst),
    .cmd_src_a(cmd_src_a),
    .cmd_src_b(cmd_src_b),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_a    (rsp_a),
    .rsp_b    (rsp_b),
    .busy     (busy),
    .WR       (WR),
    .DA       (DA),
    .D        (D),
    .AA       (AA),
    .BA       (BA),
    .A        (A),
    .B        (B)
  );

  always @(posedge Clock) if (WR) rf[DA] <= D;
  assign A = rf[AA];
  assign B = rf[BA];

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic finish_pending(input logic [AW-1:0] dst, input logic [DW-1:0] data);
    tick();
    chk("pend_we", WR, 1);
    chk("pend_da", DA, dst);
    chk("pend_d", D, data);
    cmd_valid = 1'b0;
    tick();
    chk("pend_done", {WR, cmd_ready}, 2'b01);
    mdl[dst] = data;
  endtask

  task automatic drive_pending(input bit pend, input logic [AW-1:0] dst, input logic [DW-1:0] data);
    cmd_valid = pend;
    cmd_op    = OP_WRITE;
    cmd_dst   = dst;
    cmd_data  = data;
  endtask

  task automatic do_write(input logic [AW-1:0] dst, input logic [DW-1:0] data);
    chk("wr_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_WRITE; cmd_dst = dst; cmd_data = data;
    tick();
    cmd_valid = 1'b0;
    chk("wr_we", WR, 1);
    chk("wr_da", DA, dst);
    chk("wr_d", D, data);
    chk("wr_busy_ready", {busy, cmd_ready}, 2'b10);
    tick();
    chk("wr_done", {WR, cmd_ready, busy}, 3'b010);
    mdl[dst] = data;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b, input int hold,
                         input bit pend, input logic [AW-1:0] pdst, input logic [DW-1:0] pdata);
    chk("rd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_src_a = a; cmd_src_b = b;
    rsp_ready = 1'b0;
    tick();
    drive_pending(pend, pdst, pdata);
    chk("rd_aa", AA, a);
    chk("rd_ba", BA, b);
    chk("rd_early", {rsp_valid, WR, cmd_ready}, 3'b000);
    tick();
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_a", rsp_a, mdl[a]);
      chk("rsp_b", rsp_b, mdl[b]);
      chk("rsp_stall", {cmd_ready, WR}, 2'b00);
      if (h == hold) rsp_ready = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    chk("rsp_release", {rsp_valid, cmd_ready, busy, WR}, 4'b0100);
    if (pend) finish_pending(pdst, pdata);
  endtask

  task automatic do_clear(input bit pend, input logic [AW-1:0] pdst, input logic [DW-1:0] pdata);
    chk("clr_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_CLEAR;
    tick();
    drive_pending(pend, pdst, pdata);
    for (int i = 0; i < NR; i++) begin
      chk("clr_we", WR, 1);
      chk("clr_da", DA, i);
      chk("clr_d", D, 0);
      chk("clr_busy", {busy, cmd_ready}, 2'b10);
      tick();
    end
    chk("clr_end", {WR, busy, cmd_ready}, 3'b001);
    chk("clr_da_park", DA, 0);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    if (pend) finish_pending(pdst, pdata);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_dst = '0; cmd_src_a = '0; cmd_src_b = '0;
    cmd_data = '0; rsp_ready = 1'b0;
    Reset = 1'b0;
    repeat (3) tick();
    chk("rst_wr", WR, 0);
    chk("rst_da", DA, 0);
    chk("rst_d", D, 0);
    chk("rst_aa_ba", {AA, BA}, 0);
    chk("rst_rsp", {rsp_valid, rsp_a, rsp_b}, 0);
    chk("rst_busy", busy, 0);
    #2 Reset = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1);

    do_write(4'd3, 16'hBEEF);
    do_read(4'd3, 4'd0, 0, 1'b0, '0, '0);

    for (int i = 0; i < NR; i++) do_write(AW'(i), DW'(16'h1000 + i));
    do_clear(1'b0, '0, '0);
    do_read(4'd15, 4'd7, 0, 1'b0, '0, '0);

    do_write(4'd5, 16'h00A5);
    do_read(4'd5, 4'd5, 4, 1'b0, '0, '0);

    do_read(4'd1, 4'd2, 2, 1'b1, 4'd9, 16'h9999);
    do_clear(1'b1, 4'd4, 16'h4444);
    do_read(4'd4, 4'd9, 0, 1'b0, '0, '0);

    // Reset in the middle of a clear sweep
    for (int i = 0; i < NR; i++) do_write(AW'(i), DW'($urandom));
    cmd_valid = 1'b1; cmd_op = OP_CLEAR;
    tick();
    cmd_valid = 1'b0;
    repeat (6) tick();
    chk("mid_clr_da", {WR, DA}, {1'b1, 4'd6});
    #2 Reset = 1'b0;
    #1;
    chk("async_rst", {WR, busy, rsp_valid}, 3'b000);
    chk("async_rst_da", DA, 0);
    for (int i = 0; i < 6; i++) mdl[i] = '0;
    tick();
    tick();
    #2 Reset = 1'b1;
    tick();
    for (int i = 0; i < NR / 2; i++) do_read(AW'(i), AW'(i + NR / 2), 0, 1'b0, '0, '0);

    cmd_valid = 1'b1; cmd_op = OP_NOP;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nop", {cmd_ready, WR, rsp_valid, busy}, 4'b1000);
    end
    cmd_valid = 1'b0;

    for (int it = 0; it < 60; it++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r == 0)
        do_clear(1'($urandom), AW'($urandom), DW'($urandom));
      else if (r <= 5)
        do_write(AW'($urandom), DW'($urandom));
      else
        do_read(AW'($urandom), AW'($urandom), int'($urandom_range(0, 3)),
                1'($urandom), AW'($urandom), DW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
